uart_tx_framer: RTL and testbench

UART transmit framer. Accepts a parallel word over a valid/ready handshake and serialises it onto the TX line. The frame is a start bit, then WORD_LENGTH data bits LSB first, then an optional parity bit, then one stop bit. Each bit lasts CLKS_PER_BIT clocks. The block contains its own bit-period counter and frame FSM, and sits between the bus-side transmit register and the TX pin.

---
 rtl/uart_tx_framer.sv | 169 ++++++++++++++++
 tb/tb_uart_tx_framer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a word over valid/ready and shifts it out as
// start bit, LSB-first data, optional parity bit and one stop bit.
module uart_tx_framer #(
    parameter int WORD_LENGTH  = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tx_valid,
    input  logic [WORD_LENGTH-1:0] tx_data,
    output logic                   tx_ready,
    output logic                   serial_out,
    output logic                   busy,
    output logic                   tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_LENGTH - 1);
    localparam logic             ODD_SENSE = (PARITY_ODD != 0);
    localparam logic             HAS_PARITY = (PARITY_EN != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_W-1:0]       bit_q, bit_d;
    logic [WORD_LENGTH-1:0] data_q, data_d;
    logic                   par_q, par_d;
    logic                   ser_q, ser_d;
    logic                   rdy_q, rdy_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            par_q   <= par_d;
            ser_q   <= ser_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Outputs are computed one cycle ahead so every line level is registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        par_d   = par_q;
        ser_d   = ser_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                ser_d  = 1'b1;
                rdy_d  = 1'b1;
                busy_d = 1'b0;
                if (tx_valid) begin
                    data_d  = tx_data;
                    // Parity is captured up front because data_q is consumed by shifting.
                    par_d   = (^tx_data) ^ ODD_SENSE;
                    state_d = START;
                    cnt_d   = '0;
                    bit_d   = '0;
                    ser_d   = 1'b0;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    ser_d   = data_q[0];
                end
            end

            DATA: begin
                if (bit_end) begin
                    data_d = data_q >> 1;
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (HAS_PARITY) begin
                            state_d = PARITY;
                            ser_d   = par_q;
                        end else begin
                            state_d = STOP;
                            ser_d   = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        ser_d = data_q[1];
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    ser_d   = 1'b1;
                end
            end

            STOP: begin
                // Registered pulse lands on the final cycle of the stop bit.
                if (cnt_q == CNT_DONE) begin
                    done_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = IDLE;
                    ser_d   = 1'b1;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                ser_d   = 1'b1;
                rdy_d   = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign serial_out = ser_q;
    assign tx_ready   = rdy_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: per-cycle expected line/handshake
// values are queued when a word is sent and compared as the DUTs run.
module tb_uart_tx_framer;

    typedef struct packed {
        logic ser;
        logic done;
        logic rdy;
        logic bsy;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] vld;
    logic [7:0] d8;
    logic [4:0] d5;
    logic [3:0] ser, done, rdy, bsy;

    exp_t exp_q[4][$];
    int   n_tests;
    int   n_fail;

    uart_tx_framer #(.WORD_LENGTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .reset(rst_n), .tx_valid(vld[0]), .tx_data(d8),
        .tx_ready(rdy[0]), .serial_out(ser[0]), .busy(bsy[0]), .tx_done(done[0]));

    uart_tx_framer #(.WORD_LENGTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
        .clk(clk), .reset(rst_n), .tx_valid(vld[1]), .tx_data(d8),
        .tx_ready(rdy[1]), .serial_out(ser[1]), .busy(bsy[1]), .tx_done(done[1]));

    uart_tx_framer #(.WORD_LENGTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
        .clk(clk), .reset(rst_n), .tx_valid(vld[2]), .tx_data(d8),
        .tx_ready(rdy[2]), .serial_out(ser[2]), .busy(bsy[2]), .tx_done(done[2]));

    uart_tx_framer #(.WORD_LENGTH(5), .CLKS_PER_BIT(2), .PARITY_EN(0), .PARITY_ODD(0)) u_w5 (
        .clk(clk), .reset(rst_n), .tx_valid(vld[3]), .tx_data(d5),
        .tx_ready(rdy[3]), .serial_out(ser[3]), .busy(bsy[3]), .tx_done(done[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Monitor: one expected entry per DUT cycle, sampled 1 unit after the edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 4; i++) begin
            if (exp_q[i].size() > 0) begin
                exp_t e;
                e = exp_q[i].pop_front();
                chk($sformatf("serial_out[%0d]", i), 32'(ser[i]),  32'(e.ser));
                chk($sformatf("tx_done[%0d]", i),    32'(done[i]), 32'(e.done));
                chk($sformatf("tx_ready[%0d]", i),   32'(rdy[i]),  32'(e.rdy));
                chk($sformatf("busy[%0d]", i),       32'(bsy[i]),  32'(e.bsy));
            end
        end
    end

    task automatic push_idle(input int idx, input int n);
        exp_t e;
        e.ser = 1'b1; e.done = 1'b0; e.rdy = 1'b1; e.bsy = 1'b0;
        for (int k = 0; k < n; k++) exp_q[idx].push_back(e);
    endtask

    // Builds the whole frame from the line protocol, followed by one idle cycle.
    task automatic push_frame(input int idx, input logic [8:0] data, input int wl,
                              input int c, input int pen, input int podd);
        logic bits[12];
        logic par;
        int   nb;
        exp_t e;
        par = 1'b0;
        for (int i = 0; i < wl; i++) par = par ^ data[i];
        if (podd != 0) par = ~par;
        bits[0] = 1'b0;
        for (int i = 0; i < wl; i++) bits[1 + i] = data[i];
        nb = 1 + wl;
        if (pen != 0) begin
            bits[nb] = par;
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < c; k++) begin
                e.ser  = bits[b];
                e.done = (b == nb - 1) && (k == c - 1);
                e.rdy  = 1'b0;
                e.bsy  = 1'b1;
                exp_q[idx].push_back(e);
            end
        end
        push_idle(idx, 1);
    endtask

    task automatic send(input int idx, input logic [8:0] data, input int wl,
                        input int c, input int pen, input int podd);
        push_frame(idx, data, wl, c, pen, podd);
        if (idx == 3) d5 = data[4:0];
        else          d8 = data[7:0];
        vld[idx] = 1'b1;
        @(posedge clk); #2;
        vld[idx] = 1'b0;
    endtask

    task automatic wait_empty();
        int guard;
        guard = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) > 0
               && guard < 500) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("drain_timeout", 32'(guard >= 500), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        vld     = '0;
        d8      = '0;
        d5      = '0;

        // Reset state of every instance
        @(posedge clk); #2;
        for (int i = 0; i < 4; i++) push_idle(i, 2);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        wait_empty();

        // Plain frame 8'hA5, then a settling idle cycle
        send(0, 9'h0A5, 8, 4, 0, 0);
        push_idle(0, 2);
        wait_empty();

        // Even and odd parity of 8'hA5
        send(1, 9'h0A5, 8, 4, 1, 0);
        wait_empty();
        send(2, 9'h0A5, 8, 4, 1, 1);
        wait_empty();

        // Back-to-back frames with tx_valid held high
        push_frame(0, 9'h000, 8, 4, 0, 0);
        push_frame(0, 9'h0FF, 8, 4, 0, 0);
        d8     = 8'h00;
        vld[0] = 1'b1;
        @(posedge clk); #2;
        d8 = 8'hFF;
        repeat (41) begin
            @(posedge clk); #2;
        end
        vld[0] = 1'b0;
        wait_empty();

        // Request during data bit 3 is ignored and the in-flight word is kept
        send(0, 9'h0A5, 8, 4, 0, 0);
        repeat (16) begin
            @(posedge clk); #2;
        end
        d8     = 8'h3C;
        vld[0] = 1'b1;
        @(posedge clk); #2;
        vld[0] = 1'b0;
        push_idle(0, 3);
        wait_empty();

        // Reset pulse during data bit 5 aborts the frame, then 8'h5A is framed
        send(0, 9'h0A5, 8, 4, 0, 0);
        repeat (24) begin
            @(posedge clk); #2;
        end
        exp_q[0].delete();
        push_idle(0, 3);
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        wait_empty();
        send(0, 9'h05A, 8, 4, 0, 0);
        wait_empty();

        // Five-bit word at two clocks per bit
        send(3, 9'h011, 5, 2, 0, 0);
        wait_empty();
        send(3, 9'h00A, 5, 2, 0, 0);
        wait_empty();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
